execute_stage: RTL
==================

Name: execute_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the registered decode outputs (after the D/E pipeline register) and applies M/W forwarding. It computes the ALU result and selects the destination register. It also runs a multi-cycle signed divider for DIV, producing DivHiE/DivLoE for the M/W path and a stall request for the hazard unit.

Parameters:
DIV_CYCLES, 32, quotient bits produced by the iterative divider, one per cycle; only 32 is supported.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
reg_rs_value_E  in  32  rs value from the D/E register
reg_rt_value_E  in  32  rt value from the D/E register
immediate_E  in  32  extended immediate
reg_rt_id_E  in  5  rt id
reg_rd_id_E  in  5  rd id
shamt_E  in  5  shift amount
alu_op_E  in  4  ALU operation
alu_src_E  in  1  1 = operand B is immediate_E
reg_dest_E  in  1  1 = destination is rd, 0 = rt
HasDivE  in  1  instruction in E is DIV
flush_E  in  1  hazard unit squash of the E instruction
forward_a_E  in  2  operand A forward select
forward_b_E  in  2  operand B forward select
alu_out_M  in  32  forwarded value from Memory
result_W  in  32  forwarded value from Writeback
alu_out_E  out  32  ALU result
write_data_E  out  32  forwarded rt, for store data
write_reg_E  out  5  destination register id
DivHiE  out  32  remainder
DivLoE  out  32  quotient
HasDivOutE  out  1  divide result valid this cycle
div_stall  out  1  stall request to the hazard unit

Behaviour:
- Forward mux, applied to A (rs) and B (rt): 00 = register value, 01 = result_W, 10 = alu_out_M, 11 = register value.
- write_data_E = forwarded B.
- ALU operand B = alu_src_E ? immediate_E : forwarded B.
- alu_op encoding, all combinational:
  - 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT (signed), 5 SLL, 6 SRL, 7 SRA, 8 XOR, 9 NOR, 10 SLTU, 11 LUI (B<<16).
  - 12-15 give 0.
  - Shifts shift operand B by shamt_E.
  - ADD/SUB wrap mod 2^32; no overflow trap.
- write_reg_E = reg_dest_E ? reg_rd_id_E : reg_rt_id_E.
- Divider FSM, states IDLE, RUN, DONE:
  - IDLE with HasDivE=1 and flush_E=0:
    - latch |A|, |B|, sign(A), sign(B) and raw A;
    - clear count;
    - move to RUN.
  - RUN: one restoring-division step per cycle; count increments; at count=31 move to DONE.
  - DONE: move to IDLE unconditionally next cycle.
- div_stall = HasDivE & (state != DONE), combinational. It is high for exactly 33 consecutive cycles: the entry cycle plus 32 RUN cycles. It is low in the DONE cycle, so the pipeline advances with the result.
- HasDivOutE = 1 only in DONE. DivHiE/DivLoE hold the final values in DONE and keep them until the next divide completes.
- Sign rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^31 / -1 gives lo = 0x80000000, hi = 0.
- Divide by zero (B = 0 latched): lo = 0xFFFFFFFF, hi = raw A; timing is unchanged (33 stall cycles).
- flush_E while in RUN: abort to IDLE next cycle. Hi/lo keep their previous values; HasDivOutE is not asserted.
- flush_E in DONE has no effect on state; the hazard unit is responsible for discarding the result.
- Reset, including mid-divide: state IDLE, count 0, DivHiE = DivLoE = 0, HasDivOutE = 0. div_stall then follows HasDivE.
- alu_out_E, write_data_E and write_reg_E are purely combinational and have no reset value.

Decomposition:
- Shared package: alu_op encodings, forward-select encodings, divider state encodings, DIV_CYCLES.
- Sub-module div_unit: the FSM, datapath and sign fix-up, with ports start, abort, a, b, busy, done, hi, lo.
- ALU and forwarding muxes stay inline in execute_stage.

Test Plan:
- ADD, A=0x7FFFFFFF, B=1 (forward 00) -> alu_out_E = 0x80000000.
- SUB with forward_a=10, alu_out_M=5, rt=7 -> alu_out_E = 0xFFFFFFFE.
- SRA, B=0x80000000, shamt=4 -> 0xF8000000.
- SLT vs SLTU on A=0xFFFFFFFF, B=1 -> 1 and 0 respectively.
- DIV -7/2 -> div_stall high for exactly 33 cycles; DONE gives lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1), HasDivOutE pulses for 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIV 9/0 -> lo = 0xFFFFFFFF, hi = 9.
- flush_E at RUN count 10 -> IDLE next cycle, no HasDivOutE, hi/lo unchanged.
- reset_n low at count 20 -> immediate IDLE, DivHiE = DivLoE = 0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared encodings and helpers for the MIPS execute stage
package execute_stage_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_XOR  = 4'd8,
    ALU_NOR  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'd0,
    FWD_W       = 2'd1,
    FWD_M       = 2'd2,
    FWD_REG_ALT = 2'd3
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] m_v, input logic [31:0] w_v);
    case (fwd_sel_e'(sel))
      FWD_W:   return w_v;
      FWD_M:   return m_v;
      default: return reg_v;
    endcase
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - execute stage pipeline-side signal bundle
interface execute_stage_if;
  logic [31:0] reg_rs_value_E;
  logic [31:0] reg_rt_value_E;
  logic [31:0] immediate_E;
  logic [4:0]  reg_rt_id_E;
  logic [4:0]  reg_rd_id_E;
  logic [4:0]  shamt_E;
  logic [3:0]  alu_op_E;
  logic        alu_src_E;
  logic        reg_dest_E;
  logic        HasDivE;
  logic        flush_E;
  logic [1:0]  forward_a_E;
  logic [1:0]  forward_b_E;
  logic [31:0] alu_out_M;
  logic [31:0] result_W;
  logic [31:0] alu_out_E;
  logic [31:0] write_data_E;
  logic [4:0]  write_reg_E;
  logic [31:0] DivHiE;
  logic [31:0] DivLoE;
  logic        HasDivOutE;
  logic        div_stall;

  modport master (
    output reg_rs_value_E, reg_rt_value_E, immediate_E, reg_rt_id_E, reg_rd_id_E, shamt_E,
           alu_op_E, alu_src_E, reg_dest_E, HasDivE, flush_E, forward_a_E, forward_b_E,
           alu_out_M, result_W,
    input  alu_out_E, write_data_E, write_reg_E, DivHiE, DivLoE, HasDivOutE, div_stall
  );

  modport slave (
    input  reg_rs_value_E, reg_rt_value_E, immediate_E, reg_rt_id_E, reg_rd_id_E, shamt_E,
           alu_op_E, alu_src_E, reg_dest_E, HasDivE, flush_E, forward_a_E, forward_b_E,
           alu_out_M, result_W,
    output alu_out_E, write_data_E, write_reg_E, DivHiE, DivLoE, HasDivOutE, div_stall
  );
endinterface

// File: rtl/execute_stage_div_unit.sv
// rtl/execute_stage_div_unit.sv - iterative signed restoring divider, one quotient bit per cycle
module execute_stage_div_unit
  import execute_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  div_state_e  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d, raw_a_q, raw_a_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic [32:0] shifted, diff;
  logic        ge;
  logic [31:0] rem_n, quot_n;

  // Quotient register doubles as the dividend shift register.
  assign shifted = {rem_q, quot_q[31]};
  assign diff    = shifted - {1'b0, divisor_q};
  assign ge      = ~diff[32];
  assign rem_n   = ge ? diff[31:0] : shifted[31:0];
  assign quot_n  = {quot_q[30:0], ge};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      raw_a_q   <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      raw_a_q   <= raw_a_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    raw_a_d   = raw_a_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          state_d   = DIV_RUN;
          count_d   = '0;
          rem_d     = '0;
          quot_d    = abs32(a);
          divisor_d = abs32(b);
          raw_a_d   = a;
          sign_a_d  = a[31];
          sign_b_d  = b[31];
        end
      end
      DIV_RUN: begin
        if (abort) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d   = rem_n;
          quot_d  = quot_n;
          count_d = count_q + 5'd1;
          // Results are committed only on the final step so an abort leaves hi/lo intact.
          if (count_q == 5'(DIV_CYCLES - 1)) begin
            state_d = DIV_DONE;
            if (divisor_q == '0) begin
              lo_d = 32'hFFFF_FFFF;
              hi_d = raw_a_q;
            end else begin
              lo_d = (sign_a_q ^ sign_b_q) ? -quot_n : quot_n;
              hi_d = sign_a_q ? -rem_n : rem_n;
            end
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // busy means "no result this cycle", so a DIV in E stalls exactly until DONE.
  assign busy = (state_q != DIV_DONE);
  assign done = (state_q == DIV_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS execute stage: forwarding, ALU, destination select, divider hookup
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  execute_stage_if.slave  bus
);

  logic [31:0] src_a, src_b, op_b, alu_res;
  logic        div_busy, div_done;

  assign src_a = fwd_mux(bus.forward_a_E, bus.reg_rs_value_E, bus.alu_out_M, bus.result_W);
  assign src_b = fwd_mux(bus.forward_b_E, bus.reg_rt_value_E, bus.alu_out_M, bus.result_W);
  assign op_b  = bus.alu_src_E ? bus.immediate_E : src_b;

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.alu_op_E))
      ALU_AND:  alu_res = src_a & op_b;
      ALU_OR:   alu_res = src_a | op_b;
      ALU_ADD:  alu_res = src_a + op_b;
      ALU_SUB:  alu_res = src_a - op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(src_a) < $signed(op_b)};
      ALU_SLL:  alu_res = op_b << bus.shamt_E;
      ALU_SRL:  alu_res = op_b >> bus.shamt_E;
      ALU_SRA:  alu_res = $signed(op_b) >>> bus.shamt_E;
      ALU_XOR:  alu_res = src_a ^ op_b;
      ALU_NOR:  alu_res = ~(src_a | op_b);
      ALU_SLTU: alu_res = {31'd0, src_a < op_b};
      ALU_LUI:  alu_res = {op_b[15:0], 16'd0};
      default:  alu_res = '0;
    endcase
  end

  assign bus.alu_out_E    = alu_res;
  assign bus.write_data_E = src_b;
  assign bus.write_reg_E  = bus.reg_dest_E ? bus.reg_rd_id_E : bus.reg_rt_id_E;

  execute_stage_div_unit u_div_unit (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (bus.HasDivE & ~bus.flush_E),
    .abort   (bus.flush_E),
    .a       (src_a),
    .b       (src_b),
    .busy    (div_busy),
    .done    (div_done),
    .hi      (bus.DivHiE),
    .lo      (bus.DivLoE)
  );

  assign bus.HasDivOutE = div_done;
  assign bus.div_stall  = bus.HasDivE & div_busy;

endmodule
